// File: rtl/vr_elastic_pipe_pkg.sv
// Shared types and helpers for the valid/ready elastic pipeline.
// Holds the default payload width, the slice state encoding and the occupancy width rule.
package vr_elastic_pipe_pkg;

   localparam int unsigned DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } slice_state_e;

   // Each slice holds at most two entries, so the count spans 0..2*stages.
   function automatic int unsigned occ_width(input int unsigned stages);
      return $clog2(2 * stages + 1);
   endfunction

endpackage

// File: rtl/vr_skid_slice.sv
// One elastic pipeline stage: a 2-entry skid buffer with a registered ready,
// or a single register whose ready passes combinationally from downstream.
module vr_skid_slice
   import vr_elastic_pipe_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter bit          REG_READY = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              up_valid,
   input  logic [DATA_W-1:0] up_data,
   output logic              up_ready,
   output logic              dn_valid,
   output logic [DATA_W-1:0] dn_data,
   input  logic              dn_ready
);

   if (REG_READY) begin : g_skid
      slice_state_e      state, state_nxt;
      logic [DATA_W-1:0] main_data, skid_data;
      logic              rdy_q;
      logic              up_fire, dn_fire;
      logic              load_main, load_skid, shift_skid;

      assign up_fire = up_valid & rdy_q;
      assign dn_fire = (state != ST_EMPTY) & dn_ready;

      // rdy_q tracks "skid slot free after this edge", so it is low only in FULL.
      always_ff @(posedge clk) begin
         if (rst) begin
            state <= ST_EMPTY;
            rdy_q <= 1'b0;
         end else if (flush) begin
            state <= ST_EMPTY;
            rdy_q <= 1'b1;
         end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt != ST_FULL);
         end
      end

      always_comb begin
         state_nxt = state;
         case (state)
            ST_EMPTY: if (up_fire) state_nxt = ST_ONE;
            ST_ONE: begin
               if (up_fire && !dn_fire)      state_nxt = ST_FULL;
               else if (!up_fire && dn_fire) state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (dn_fire) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
         endcase
      end

      always_comb begin
         up_ready   = rdy_q;
         dn_valid   = (state != ST_EMPTY);
         dn_data    = main_data;
         load_main  = 1'b0;
         load_skid  = 1'b0;
         shift_skid = 1'b0;
         case (state)
            ST_EMPTY: load_main = up_fire;
            ST_ONE: begin
               load_main = up_fire & dn_fire;
               load_skid = up_fire & ~dn_fire;
            end
            ST_FULL:  shift_skid = dn_fire;
            default: ;
         endcase
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            main_data <= '0;
            skid_data <= '0;
         end else if (!flush) begin
            if (load_main)       main_data <= up_data;
            else if (shift_skid) main_data <= skid_data;
            if (load_skid)       skid_data <= up_data;
         end
      end
   end else begin : g_reg
      logic              main_v;
      logic [DATA_W-1:0] main_data;
      logic              up_fire, dn_fire;

      assign up_ready = ~rst & (~main_v | dn_ready);
      assign up_fire  = up_valid & up_ready;
      assign dn_fire  = main_v & dn_ready;
      assign dn_valid = main_v;
      assign dn_data  = main_data;

      always_ff @(posedge clk) begin
         if (rst) begin
            main_v    <= 1'b0;
            main_data <= '0;
         end else begin
            if (flush)        main_v <= 1'b0;
            else if (up_fire) main_v <= 1'b1;
            else if (dn_fire) main_v <= 1'b0;
            if (up_fire && !flush) main_data <= up_data;
         end
      end
   end

endmodule

// File: rtl/vr_elastic_pipe.sv
// Valid/ready elastic pipeline: STAGES chained slices plus a registered
// occupancy count and a synchronous flush shared by every slice.
module vr_elastic_pipe
   import vr_elastic_pipe_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned STAGES    = 2,
   parameter bit          REG_READY = 1'b1,
   parameter int unsigned OCC_W     = occ_width(STAGES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [OCC_W-1:0]  occupancy
);

   logic in_fire, out_fire;

   // Per-stage link signals live in separate scopes so the combinational
   // ready chain of the register variant never loops through one vector.
   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      logic              up_valid, up_ready, dn_valid, dn_ready;
      logic [DATA_W-1:0] up_data, dn_data;

      if (g == 0) begin : g_src
         assign up_valid = in_valid;
         assign up_data  = in_data;
      end else begin : g_link
         assign up_valid = g_stage[g-1].dn_valid;
         assign up_data  = g_stage[g-1].dn_data;
      end

      if (g == STAGES - 1) begin : g_snk
         assign dn_ready = out_ready;
      end else begin : g_bp
         assign dn_ready = g_stage[g+1].up_ready;
      end

      vr_skid_slice #(
         .DATA_W   (DATA_W),
         .REG_READY(REG_READY)
      ) u_slice (
         .clk     (clk),
         .rst     (rst),
         .flush   (flush),
         .up_valid(up_valid),
         .up_data (up_data),
         .up_ready(up_ready),
         .dn_valid(dn_valid),
         .dn_data (dn_data),
         .dn_ready(dn_ready)
      );
   end

   assign in_ready  = g_stage[0].up_ready;
   assign out_valid = g_stage[STAGES-1].dn_valid;
   assign out_data  = g_stage[STAGES-1].dn_data;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst || flush) occupancy <= '0;
      else              occupancy <= occupancy + OCC_W'(in_fire) - OCC_W'(out_fire);
   end

endmodule

// File: tb/tb_vr_elastic_pipe.sv
// Bench for vr_elastic_pipe: a skid-mode 2-stage pipe and a register-mode 3-stage
// pipe share one stimulus stream and are each checked against a queue-per-stage model.
module tb_vr_elastic_pipe;

   logic       clk, rst, flush, in_valid, out_ready;
   logic [7:0] in_data;

   logic       a_in_ready, a_out_valid;
   logic [7:0] a_out_data;
   logic [2:0] a_occ;
   logic       b_in_ready, b_out_valid;
   logic [7:0] b_out_data;
   logic [2:0] b_occ;

   vr_elastic_pipe #(.DATA_W(8), .STAGES(2), .REG_READY(1'b1)) u_dut_a (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
      .out_ready(out_ready), .occupancy(a_occ));

   vr_elastic_pipe #(.DATA_W(8), .STAGES(3), .REG_READY(1'b0)) u_dut_b (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
      .out_ready(out_ready), .occupancy(b_occ));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: index 0 = skid pipe (2 stages, ready = "fewer than 2 held" after last edge),
   // index 1 = register pipe (3 stages, ready = "stage empty or next stage ready").
   logic [7:0] md [2][3][2];
   int         mc [2][3];
   logic [7:0] mh [2][3];
   bit         rq [2][3];
   int         cyc = 0;

   function automatic int ns(input int k);
      return (k == 0) ? 2 : 3;
   endfunction

   function automatic bit m_ready(input int k, input int i);
      bit r;
      if (i >= ns(k)) return out_ready;
      if (k == 0) return rq[k][i];
      if (rst) return 1'b0;
      r = out_ready;
      for (int j = ns(k) - 1; j >= i; j--) r = (mc[k][j] == 0) || r;
      return r;
   endfunction

   function automatic int msum(input int k);
      int s = 0;
      for (int i = 0; i < ns(k); i++) s += mc[k][i];
      return s;
   endfunction

   task automatic m_step(input int k);
      bit         f  [4];
      logic [7:0] bd [4];
      int         s;
      s = ns(k);
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            mc[k][i] = 0; mh[k][i] = 8'h00; rq[k][i] = 1'b0;
         end
         return;
      end
      for (int i = 0; i <= s; i++) begin
         bit v;
         v     = (i == 0) ? in_valid : (mc[k][i-1] > 0);
         f[i]  = v && m_ready(k, i);
         bd[i] = (i == 0) ? in_data : md[k][i-1][0];
      end
      for (int i = 0; i < s; i++) begin
         if (flush) begin
            mc[k][i] = 0;
         end else begin
            if (f[i+1]) begin
               md[k][i][0] = md[k][i][1];
               mc[k][i]--;
            end
            if (f[i]) begin
               md[k][i][mc[k][i]] = bd[i];
               mc[k][i]++;
            end
            if (mc[k][i] > 0) mh[k][i] = md[k][i][0];
         end
         rq[k][i] = (mc[k][i] < 2);
      end
   endtask

   always @(posedge clk) begin
      m_step(0);
      m_step(1);
      cyc++;
   end

   bit         chk_en = 1'b0;
   bit         a_acc, b_acc;
   int         acc_cyc [$];
   int         out_cyc [$];
   logic [7:0] out_dat [$];
   int         b_in_cnt, b_out_cnt, occ_max;

   always @(negedge clk) begin
      #1;
      if (chk_en) begin
         chk("a_out_valid", a_out_valid, mc[0][1] > 0);
         chk("a_out_data",  a_out_data,  mh[0][1]);
         chk("a_in_ready",  a_in_ready,  m_ready(0, 0));
         chk("a_occupancy", a_occ,       msum(0));
         chk("b_out_valid", b_out_valid, mc[1][2] > 0);
         chk("b_out_data",  b_out_data,  mh[1][2]);
         chk("b_in_ready",  b_in_ready,  m_ready(1, 0));
         chk("b_occupancy", b_occ,       msum(1));
         chk("b_occ_cap",   b_occ <= 3,  1);
         if (b_occ == 3) chk("b_full_ready_eq_out_ready", b_in_ready, out_ready);
      end
      a_acc = !rst && in_valid && a_in_ready;
      b_acc = !rst && in_valid && b_in_ready;
      if (a_acc && !flush) acc_cyc.push_back(cyc);
      if (!rst && a_out_valid && out_ready) begin
         out_cyc.push_back(cyc);
         out_dat.push_back(a_out_data);
      end
      if (b_acc && !flush) b_in_cnt++;
      if (!rst && b_out_valid && out_ready) b_out_cnt++;
      if (int'(a_occ) > occ_max) occ_max = int'(a_occ);
   end

   task automatic clear_logs();
      acc_cyc.delete(); out_cyc.delete(); out_dat.delete(); occ_max = 0;
   endtask

   task automatic drain(input int n);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   int idx;

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

      // Reset and idle
      @(negedge clk); chk_en = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_out_data",  a_out_data,  8'h00);
      chk("rst_occupancy", a_occ,       0);
      chk("rst_in_ready",  a_in_ready,  0);
      @(negedge clk); rst = 1'b0;
      #2 chk("in_ready_before_edge", a_in_ready, 0);
      @(negedge clk);
      #2 chk("in_ready_after_edge", a_in_ready, 1);

      // Streaming 0x01..0x10
      clear_logs();
      for (int v = 1; v <= 16; v++) begin
         @(negedge clk);
         out_ready = 1'b1; in_valid = 1'b1; in_data = 8'(v);
         if (v == 9) begin
            #2 chk("stream_occ", a_occ, 2);
         end
      end
      @(negedge clk); in_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      chk("stream_acc_n", acc_cyc.size(), 16);
      chk("stream_out_n", out_dat.size(), 16);
      chk("stream_occ_max", occ_max, 2);
      if (acc_cyc.size() == 16) chk("stream_span", acc_cyc[15] - acc_cyc[0], 15);
      for (int i = 0; i < 16; i++) begin
         if (i < out_dat.size() && i < acc_cyc.size()) begin
            chk("stream_data", out_dat[i], i + 1);
            chk("stream_latency", out_cyc[i] - acc_cyc[i], 2);
         end
      end

      // Back-pressure 0x20..0x27
      @(negedge clk); out_ready = 1'b0; in_valid = 1'b0;
      clear_logs(); idx = 0;
      repeat (10) begin
         @(negedge clk);
         if (in_valid && a_acc) idx++;
         in_valid = (idx < 8); in_data = 8'(32 + idx);
      end
      #2;
      chk("bp_accepted", acc_cyc.size(), 4);
      chk("bp_occ", a_occ, 4);
      chk("bp_model_occ", msum(0), 4);
      chk("bp_in_ready", a_in_ready, 0);
      chk("bp_out_valid", a_out_valid, 1);
      chk("bp_out_data_held", a_out_data, 8'h20);
      for (int t = 0; t < 40 && idx < 8; t++) begin
         @(negedge clk);
         out_ready = 1'b1;
         if (in_valid && a_acc) idx++;
         in_valid = (idx < 8); in_data = 8'(32 + idx);
      end
      chk("bp_all_accepted", idx, 8);
      drain(8);
      #2;
      chk("bp_out_n", out_dat.size(), 8);
      for (int i = 0; i < 8; i++)
         if (i < out_dat.size()) chk("bp_out_data", out_dat[i], 32 + i);

      // Random traffic with occasional flush
      for (int t = 0; t < 1000; t++) begin
         @(negedge clk);
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         flush     = ($urandom_range(0, 99) == 0);
      end
      drain(10);

      // Flush of a full pipe with a concurrent offer
      @(negedge clk); out_ready = 1'b0; idx = 0;
      repeat (8) begin
         @(negedge clk);
         if (in_valid && a_acc) idx++;
         in_valid = (idx < 4); in_data = 8'(48 + idx);
      end
      #2 chk("fl_fill_occ", a_occ, 4);
      @(negedge clk); flush = 1'b1; in_valid = 1'b1; in_data = 8'h34;
      @(negedge clk); flush = 1'b0; in_valid = 1'b0;
      #2;
      chk("fl_occ", a_occ, 0);
      chk("fl_model_occ", msum(0), 0);
      chk("fl_out_valid", a_out_valid, 0);
      chk("fl_in_ready", a_in_ready, 1);
      clear_logs();
      drain(6);
      #2 chk("fl_nothing_out", out_dat.size(), 0);

      // Register-mode pipe with out_ready toggling
      @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h40;
      repeat (5) begin
         @(negedge clk);
         if (b_acc) in_data = in_data + 8'd1;
      end
      #2;
      chk("b_fill_occ", b_occ, 3);
      chk("b_fill_in_ready", b_in_ready, 0);
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (b_acc) in_data = in_data + 8'd1;
         out_ready = (t % 2 == 0);
         if (t == 0) begin
            b_in_cnt = 0; b_out_cnt = 0;
         end
      end
      #2;
      chk("b_toggle_in_n", b_in_cnt, 10);
      chk("b_toggle_out_n", b_out_cnt, 10);
      chk("b_toggle_occ", b_occ, 3);
      drain(8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vr_elastic_pipe.md
Name: vr_elastic_pipe

Overview:
- Parametrised valid/ready elastic pipeline. Successor to the single-register requester/completer pair.
- Chains STAGES register slices between an upstream sender and a downstream sink. Sustains one transfer per cycle under arbitrary back-pressure without dropping or duplicating data.
- Optional registered-ready mode (skid buffer per stage) breaks the ready timing path; also provides synchronous flush and an occupancy count.
- Sits between producer/consumer blocks wherever a timing cut or decoupling is needed.

Parameters:
- DATA_W, 8, payload width in bits.
- STAGES, 2, number of slices, ≥1.
- REG_READY, 1
  - 1: each slice is a 2-entry skid buffer, so in_ready is a flop output.
  - 0: each slice is a 1-entry register, with ready combinational through the slice.
- OCC_W, $clog2(2*STAGES+1), occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous discard of all held entries.
- in_valid  in  1  upstream valid.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  pipe can accept.
- out_valid  out  1  downstream valid.
- out_data  out  DATA_W  downstream payload.
- out_ready  in  1  downstream can accept.
- occupancy  out  OCC_W  entries currently held.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Transfer rule: a transfer occurs on a rising edge where valid&&ready. in_fire = in_valid&&in_ready; out_fire = out_valid&&out_ready.
- Reset: rst has priority over flush and all handshakes. After reset every output is 0: out_valid=0, out_data=0, occupancy=0, in_ready=0.
  - REG_READY=1: in_ready rises to 1 on the first edge after rst deasserts.
  - REG_READY=0: in_ready = ~main_v | downstream ready, i.e. 1 once rst is low.
- Stability: while out_valid=1 and out_ready=0, out_valid and out_data hold unchanged until out_fire. Data is never dropped, duplicated or reordered.
- Slice FSM, REG_READY=1. Registers: main(data,v), skid(data,v), rdy_q. States:
  - EMPTY (main_v=0)
    - in_fire → main<=in; go to ONE.
  - ONE (main_v=1, skid_v=0)
    - in_fire & s_fire → main<=in; stay ONE.
    - in_fire & !s_fire → skid<=in; go to FULL.
    - !in_fire & s_fire → go to EMPTY.
  - FULL (main_v=1, skid_v=1)
    - ready to the upstream stage is 0.
    - s_fire → main<=skid, skid_v<=0; go to ONE.
  - rdy_q next = ~(next skid_v).
  - s_fire means the slice's output handshake.
- Slice, REG_READY=0:
  - Single register; up_ready = ~main_v | dn_ready.
  - Load on up_fire; clear main_v on dn_fire without up_fire.
- Latency and throughput: empty pipe, out_ready=1 → in_data appears on out_data exactly STAGES cycles after in_fire. Sustained throughput is 1 transfer/cycle in both modes.
- Flush:
  - Clears every main_v/skid_v on the edge where flush=1; occupancy=0 the next cycle.
  - An in_fire in the flush cycle is discarded.
  - out_fire in the flush cycle still counts as delivered.
  - In REG_READY=1 mode, in_ready=1 after flush.
- Occupancy:
  - Sum of all main_v+skid_v, registered. Updated as occ + in_fire − out_fire, with 0 on flush/rst.
  - Never exceeds 2*STAGES (REG_READY=1) or STAGES (REG_READY=0).
  - Simultaneous in_fire and out_fire leaves it unchanged.
- Full pipe: in_ready=0. This is held at least one cycle after out_ready rises in REG_READY=1 mode, since ready is registered.
- Data registers reset to 0 and are only written on load, so idle bubbles do not toggle out_data.

Decomposition:
- Shared package holds:
  - the DATA_W default constant;
  - the slice state enum (ST_EMPTY, ST_ONE, ST_FULL);
  - the occupancy width function.
- Sub-module vr_skid_slice: one stage with both REG_READY variants, selected by generate. The top instantiates STAGES of them in a generate chain and owns the occupancy counter and flush fan-out.

Test Plan (DATA_W=8, STAGES=2, REG_READY=1 unless noted):
1. Reset/idle: hold rst 3 cycles → out_valid=0, out_data=0x00, occupancy=0, in_ready=0. in_ready=1 one edge after rst falls.
2. Streaming: out_ready=1, send 0x01..0x10 back-to-back → each appears at the output 2 cycles after acceptance, in order, 16 transfers in 16 cycles, occupancy steady at 2.
3. Back-pressure: out_ready=0, offer 0x20..0x27 →
   - exactly 4 accepted (0x20..0x23) and occupancy=4;
   - in_ready=0 from then on and out_data held at 0x20;
   - after out_ready=1, 0x20..0x27 all arrive in order, with none lost.
4. Random stalls: random in_valid/out_ready (50%) for 1000 cycles → scoreboard exact match, occupancy equals scoreboard depth every cycle.
5. Flush: fill to 4 entries (0x30..0x33), pulse flush with in_valid=1 and in_data=0x34 → next cycle occupancy=0, out_valid=0, in_ready=1; 0x34 is never output.
6. REG_READY=0, STAGES=3: out_ready toggling 1,0,1,0 with continuous input →
   - throughput matches out_ready duty;
   - in_ready equals out_ready in the same cycle when full;
   - occupancy ≤ 3.
